// File: rtl/asymfifo_pkt_push_arb.sv
// Packet-granular round-robin arbiter for the narrow write port of an asymmetric FIFO.
// Holds a grant for a whole packet and flushes any partial output word at packet end.
module asymfifo_pkt_push_arb #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8,
  parameter int RATIO  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   fifo_push_req_n,
  output logic                   fifo_flush_n,
  output logic [DATA_W-1:0]      fifo_data_in,
  input  logic                   fifo_full,
  input  logic                   fifo_ram_full,
  input  logic                   fifo_part_wd,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic                   err_flush
);

  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

  state_t          state;
  logic [1:0]      rr_ptr;
  logic [2:0]      byte_cnt;
  logic [3:0]      cnt_inc;
  logic            word_done;
  logic [NREQ-1:0] grant_mask;
  logic            grant_valid;
  logic            grant_last;
  logic            accept;
  logic            flush_fire;
  logic            found;
  logic [1:0]      winner;
  logic [1:0]      rr_next;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default is how latches get inferred.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = rr_ptr;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = 2'(idx);
      end
    end
  end

  assign rr_next     = (int'(winner) == NREQ - 1) ? 2'd0 : winner + 2'd1;
  assign grant_mask  = NREQ'(1) << grant_id;
  assign grant_valid = |(req_valid & grant_mask);
  assign grant_last  = |(req_last & grant_mask);
  assign cnt_inc     = {1'b0, byte_cnt} + 4'd1;
  assign word_done   = (cnt_inc == 4'(RATIO));

  // Outputs are gated by rst so nothing is pushed or flushed in the reset cycle.
  assign accept     = !rst && (state == XFER) && grant_valid && !fifo_full;
  assign flush_fire = !rst && (state == FLUSH) && !fifo_ram_full;

  assign req_ready       = accept ? grant_mask : '0;
  assign fifo_push_req_n = !accept;
  assign fifo_flush_n    = !flush_fire;
  assign fifo_data_in    = req_data[int'(grant_id)*DATA_W +: DATA_W];
  assign busy            = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      byte_cnt  <= 3'd0;
      grant_id  <= 2'd0;
      err_flush <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= winner;
            rr_ptr   <= rr_next;
            state    <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            if (grant_last) begin
              // An unfinished output word is closed by a flush before the next packet.
              if (word_done) begin
                byte_cnt <= 3'd0;
                state    <= IDLE;
              end else begin
                state <= FLUSH;
              end
            end else begin
              byte_cnt <= word_done ? 3'd0 : cnt_inc[2:0];
            end
          end
        end
        FLUSH: begin
          if (!fifo_ram_full) begin
            byte_cnt <= 3'd0;
            state    <= IDLE;
            if (!fifo_part_wd) err_flush <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asymfifo_pkt_push_arb.sv
// Bench for asymfifo_pkt_push_arb: directed scenarios plus randomized traffic,
// scored against a packet-level round-robin schedule of expected push/flush events.
module tb_asymfifo_pkt_push_arb;
  localparam int NREQ   = 2;
  localparam int DATA_W = 8;
  localparam int RATIO  = 2;
  localparam int WORD_W = DATA_W * RATIO;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_push_req_n;
  logic                   fifo_flush_n;
  logic [DATA_W-1:0]      fifo_data_in;
  logic                   fifo_full;
  logic                   fifo_ram_full;
  logic                   fifo_part_wd;
  logic [1:0]             grant_id;
  logic                   busy;
  logic                   err_flush;

  asymfifo_pkt_push_arb #(.NREQ(NREQ), .DATA_W(DATA_W), .RATIO(RATIO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_push_req_n(fifo_push_req_n), .fifo_flush_n(fifo_flush_n), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_ram_full(fifo_ram_full), .fifo_part_wd(fifo_part_wd),
    .grant_id(grant_id), .busy(busy), .err_flush(err_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    bit                is_flush;
    logic [DATA_W-1:0] data;
    logic [1:0]        gid;
  } ev_t;

  beat_t             rq[NREQ][$];
  ev_t               exp_q[$];
  bit                started[NREQ];
  int                rr_model;
  int                model_part;
  logic [WORD_W-1:0] word_acc;
  logic [WORD_W-1:0] words[$];
  int                push_cyc[$];
  int                cyc;
  int                vectors;
  int                miscompares;
  bit                full_rand, ram_rand, gap_en;
  logic              full_ovr, ram_ovr;
  logic              s_push_n, s_flush_n, s_busy;
  logic [NREQ-1:0]   s_ready;
  logic [1:0]        s_gid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int r, input int len, input logic [DATA_W-1:0] base, input bit rnd);
    for (int j = 0; j < len; j++) begin
      beat_t b;
      b.data = rnd ? DATA_W'($urandom) : base + DATA_W'(j);
      b.last = (j == len - 1);
      rq[r].push_back(b);
    end
  endtask

  // Expected event order from the round-robin rule applied to whole packets.
  task automatic schedule();
    int pos[NREQ];
    for (int i = 0; i < NREQ; i++) pos[i] = 0;
    forever begin
      int g;
      int len;
      bit lastb;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (rr_model + k) % NREQ;
        if (g < 0 && pos[i] < rq[i].size()) g = i;
      end
      if (g < 0) break;
      len = 0;
      do begin
        exp_q.push_back('{1'b0, rq[g][pos[g]].data, 2'(g)});
        lastb = rq[g][pos[g]].last;
        pos[g]++;
        len++;
      end while (!lastb);
      if (len % RATIO != 0) exp_q.push_back('{1'b1, '0, 2'(g)});
      rr_model = (g + 1) % NREQ;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      rq[i].delete();
      started[i] = 1'b0;
    end
    exp_q.delete();
    rr_model   = 0;
    model_part = 0;
    word_acc   = '0;
  endtask

  // One clock: drive inputs, sample mid-cycle, score, advance past the edge.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    ev_t ev;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = started[i] ? (gap_en ? ($urandom % 4 != 0) : 1'b1) : 1'b1;
        req_data[i*DATA_W +: DATA_W] = rq[i][0].data;
        req_last[i] = rq[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    fifo_full     = full_rand ? ($urandom % 4 == 0) : full_ovr;
    fifo_ram_full = ram_rand ? ($urandom % 3 == 0) : ram_ovr;
    fifo_part_wd  = (model_part != 0);
    @(negedge clk);
    s_push_n  = fifo_push_req_n;
    s_flush_n = fifo_flush_n;
    s_ready   = req_ready;
    s_busy    = busy;
    s_gid     = grant_id;
    if (rst) begin
      check("rst_ready", req_ready, 0);
      check("rst_push_n", fifo_push_req_n, 1);
      check("rst_flush_n", fifo_flush_n, 1);
      model_part = 0;
    end else begin
      check("push_flush_excl", !fifo_push_req_n && !fifo_flush_n, 0);
      exp_rdy = fifo_push_req_n ? '0 : NREQ'(1) << grant_id;
      check("ready_onehot", req_ready, exp_rdy);
      if (!fifo_push_req_n) begin
        check("push_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          check("push_not_flush", ev.is_flush, 0);
          check("push_data", fifo_data_in, ev.data);
          check("push_grant", grant_id, ev.gid);
        end
        word_acc = word_acc | (WORD_W'(fifo_data_in) << (DATA_W * model_part));
        model_part = (model_part + 1) % RATIO;
        if (model_part == 0) begin
          words.push_back(word_acc);
          word_acc = '0;
        end
        push_cyc.push_back(cyc);
      end
      if (!fifo_flush_n) begin
        check("flush_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          check("flush_not_push", ev.is_flush, 1);
          check("flush_grant", grant_id, ev.gid);
        end
        check("flush_part_wd", fifo_part_wd, 1);
        model_part = 0;
        word_acc   = '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && rq[i].size() > 0) begin
          started[i] = !rq[i][0].last;
          void'(rq[i].pop_front());
        end
      end
      check("err_flush_low", err_flush, 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    check("idle_after_drain", busy, 0);
  endtask

  task automatic wait_pushes(input int target, input int max_cyc);
    int n;
    n = 0;
    while (push_cyc.size() < target && n < max_cyc) begin
      step();
      n++;
    end
    check("push_wait_timeout", push_cyc.size(), target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    clear_model();
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    full_rand = 0; ram_rand = 0; gap_en = 0;
    full_ovr = 0; ram_ovr = 0;
    req_valid = '0; req_data = '0; req_last = '0;
    fifo_full = 0; fifo_ram_full = 0; fifo_part_wd = 0;
    clear_model();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("reset_busy", s_busy, 0);
    check("reset_grant", s_gid, 0);
    check("reset_err_flush", err_flush, 0);

    // Even packet: two whole words, no flush.
    words.delete();
    add_pkt(0, 4, 8'h11, 0);
    schedule();
    drain(50);
    check("t1_word_count", words.size(), 2);
    check("t1_word0", words[0], 16'h1211);
    check("t1_word1", words[1], 16'h1413);

    // Odd packet: three pushes then one flush with part_wd high.
    add_pkt(0, 3, 8'hA1, 0);
    schedule();
    drain(50);
    check("t2_err_flush", err_flush, 0);

    // Both requesters valid from reset: R0,R1,R0,R1 with one bubble per packet.
    do_reset();
    push_cyc.delete();
    add_pkt(0, 2, 8'h30, 0);
    add_pkt(1, 2, 8'h40, 0);
    add_pkt(0, 2, 8'h32, 0);
    add_pkt(1, 2, 8'h42, 0);
    schedule();
    drain(100);
    check("t3_push_count", push_cyc.size(), 8);
    for (int p = 1; p < 8; p++)
      check("t3_spacing", push_cyc[p] - push_cyc[p-1], (p % 2 == 0) ? 2 : 1);

    // fifo_full for 5 cycles mid-packet.
    push_cyc.delete();
    add_pkt(0, 4, 8'h51, 0);
    schedule();
    wait_pushes(2, 20);
    full_ovr = 1'b1;
    repeat (5) begin
      step();
      check("t4_stall_push_n", s_push_n, 1);
      check("t4_stall_ready", s_ready, 0);
    end
    full_ovr = 1'b0;
    step();
    check("t4_resume_push_n", s_push_n, 0);
    drain(50);

    // Odd packet end with ram_full high for 3 cycles.
    ram_ovr = 1'b1;
    push_cyc.delete();
    add_pkt(1, 3, 8'h61, 0);
    schedule();
    wait_pushes(3, 20);
    repeat (3) begin
      step();
      check("t5_hold_flush_n", s_flush_n, 1);
      check("t5_hold_push_n", s_push_n, 1);
      check("t5_hold_busy", s_busy, 1);
    end
    ram_ovr = 1'b0;
    step();
    check("t5_flush_pulse", s_flush_n, 0);
    drain(10);

    // Reset after 2 of 3 beats; next grant goes to R0.
    push_cyc.delete();
    add_pkt(0, 3, 8'h71, 0);
    schedule();
    wait_pushes(2, 20);
    rst = 1'b1;
    step();
    clear_model();
    rst = 1'b0;
    step();
    check("t6_busy", s_busy, 0);
    check("t6_grant", s_gid, 0);
    check("t6_push_n", s_push_n, 1);
    check("t6_flush_n", s_flush_n, 1);
    check("t6_err_flush", err_flush, 0);
    add_pkt(1, 2, 8'h81, 0);
    add_pkt(0, 2, 8'h91, 0);
    schedule();
    check("t6_first_grant", exp_q[0].gid, 0);
    drain(50);

    // Randomized traffic with stalls, ram_full and valid gaps.
    full_rand = 1; ram_rand = 1; gap_en = 1;
    for (int round = 0; round < 12; round++) begin
      for (int r = 0; r < NREQ; r++) begin
        int npk;
        npk = $urandom_range(3, 0);
        for (int p = 0; p < npk; p++) add_pkt(r, $urandom_range(5, 1), 8'h00, 1);
      end
      schedule();
      drain(800);
    end
    full_rand = 0; ram_rand = 0; gap_en = 0;
    check("final_err_flush", err_flush, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
